// File: rtl/spin_row_assembler.sv
// Spin-row assembler: drains WIDTH-bit words from the spin-load FIFO and packs
// BYTES_PER_ROW of them (first word in the LSBs) into addressed rows for the memory writer.
module spin_row_assembler #(
  parameter int WIDTH      = 8,
  parameter int ROW_BITS   = 32,
  parameter int NUM_ROWS   = 32,
  parameter int ADDR_WIDTH = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fifo_rd_en_o,
  input  logic [WIDTH-1:0]      fifo_dout_i,
  input  logic                  fifo_empty_i,
  output logic                  row_valid_o,
  input  logic                  row_ready_i,
  output logic [ROW_BITS-1:0]   row_data_o,
  output logic [ADDR_WIDTH-1:0] row_addr_o
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | issuing FIFO reads and capturing words into the row
  // OUT    | row presented, waiting for row_ready
  // DONE   | one-cycle done pulse after the final row

  localparam int BPR = ROW_BITS / WIDTH;
  localparam int CW  = $clog2(BPR + 1);
  localparam logic [CW-1:0]         BPR_C     = CW'(BPR);
  localparam logic [CW-1:0]         BPR_M1    = CW'(BPR - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         captured_q, captured_d;
  logic                  pending_q, pending_d;
  logic [ROW_BITS-1:0]   row_data_q, row_data_d;
  logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
  logic                  rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      captured_q <= '0;
      pending_q  <= 1'b0;
      row_data_q <= '0;
      row_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      pending_q  <= pending_d;
      row_data_q <= row_data_d;
      row_addr_q <= row_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    captured_d = captured_q;
    row_data_d = row_data_q;
    row_addr_d = row_addr_q;
    // Requests are gated on !empty, so every asserted read is accepted by the FIFO.
    rd_en      = (state_q == S_LOAD) && !fifo_empty_i && (issued_q < BPR_C);
    pending_d  = rd_en;

    if (pending_q) begin
      for (int b = 0; b < BPR; b++) begin
        if (captured_q == CW'(b)) row_data_d[b*WIDTH +: WIDTH] = fifo_dout_i;
      end
      captured_d = captured_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_LOAD;
          row_addr_d = '0;
          issued_d   = '0;
          captured_d = '0;
        end
      end
      S_LOAD: begin
        if (rd_en) issued_d = issued_q + CW'(1);
        // Leave on the cycle the last word lands so the row is valid one cycle later.
        if (pending_q && (captured_q == BPR_M1)) state_d = S_OUT;
      end
      S_OUT: begin
        if (row_ready_i) begin
          if (row_addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_LOAD;
            row_addr_d = row_addr_q + ADDR_WIDTH'(1);
            issued_d   = '0;
            captured_d = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_rd_en_o = rd_en;
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_OUT);
  assign done_o       = (state_q == S_DONE);
  assign row_valid_o  = (state_q == S_OUT);
  assign row_data_o   = row_data_q;
  assign row_addr_o   = row_addr_q;

endmodule

// File: tb/tb_spin_row_assembler.sv
// Directed bench for spin_row_assembler with a behavioural registered-read FIFO
// feeding it and a handshake recorder on the row port.
module tb_spin_row_assembler;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [7:0]  dout;
  logic        empty;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic [1:0]  addr;

  spin_row_assembler #(.WIDTH(8), .ROW_BITS(32), .NUM_ROWS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .fifo_rd_en_o (rd_en),
    .fifo_dout_i  (dout),
    .fifo_empty_i (empty),
    .row_valid_o  (valid),
    .row_ready_i  (ready),
    .row_data_o   (data),
    .row_addr_o   (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  fifo_mem [0:1023];
  logic [15:0] wr_ptr = 16'd0;
  logic [15:0] rd_ptr = 16'd0;
  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
      dout   <= 8'd0;
    end else if (rd_en && !empty) begin
      dout   <= fifo_mem[rd_ptr[9:0]];
      rd_ptr <= rd_ptr + 16'd1;
    end
  end

  logic [31:0] got_data [0:255];
  logic [1:0]  got_addr [0:255];
  int got_n    = 0;
  int done_cnt = 0;
  int viol     = 0;

  // Inputs change at negedge+1, so sampling at negedge+2 sees what the next posedge sees.
  always @(negedge clk) begin
    #2;
    if (!rst && valid && ready && got_n < 256) begin
      got_data[got_n] = data;
      got_addr[got_n] = addr;
      got_n++;
    end
    if (done) done_cnt++;
    if (rd_en && empty) viol++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 16'd1;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n;
    n = 0;
    do begin
      step;
      n++;
    end while (!valid && n < limit);
    check(tag, 32'(valid), 32'd1);
  endtask

  logic [7:0]  exp_b [0:255];
  logic [31:0] snap_d, e;
  logic [1:0]  snap_a;
  int n, rd_cnt, first_rd, bad, h0, d0, loads, pushed;

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    repeat (3) step;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data",  data,       32'd0);
    check("rst_addr",  32'(addr),  32'd0);
    rst = 1'b0;
    step;

    // Two rows back to back, ready held high.
    for (int i = 1; i <= 8; i++) push(8'(i));
    start = 1'b1; ready = 1'b1;
    n = 0; rd_cnt = 0; first_rd = 0;
    do begin
      step; start = 1'b0; n++;
      if (rd_en) begin rd_cnt++; if (first_rd == 0) first_rd = n; end
    end while (!valid && n < 50);
    check("r0_latency",  n,          32'd6);
    check("r0_first_rd", first_rd,   32'd1);
    check("r0_rd_count", rd_cnt,     32'd4);
    check("r0_data",     data,       32'h04030201);
    check("r0_addr",     32'(addr),  32'd0);
    n = 0; rd_cnt = 0;
    do begin
      step; n++;
      if (rd_en) rd_cnt++;
    end while (!valid && n < 50);
    check("r1_latency",  n,          32'd6);
    check("r1_rd_count", rd_cnt,     32'd4);
    check("r1_data",     data,       32'h08070605);
    check("r1_addr",     32'(addr),  32'd1);
    step; ready = 1'b0;

    // Backpressure on row 2.
    for (int i = 9; i <= 12; i++) push(8'(i));
    wait_valid("bp_valid_timeout", 50);
    check("bp_data", data,      32'h0C0B0A09);
    check("bp_addr", 32'(addr), 32'd2);
    snap_d = data; snap_a = addr; bad = 0;
    repeat (5) begin
      step;
      if (data !== snap_d || addr !== snap_a || rd_en || !valid) bad++;
    end
    check("bp_hold", bad, 32'd0);
    h0 = got_n; ready = 1'b1;
    step;
    check("bp_one_hs",   got_n - h0, 32'd1);
    check("bp_valid_lo", 32'(valid), 32'd0);
    ready = 1'b0;

    // Empty stall mid-row on row 3, then the final handshake.
    push(8'hAA); push(8'hBB);
    bad = 0;
    repeat (10) begin step; if (valid) bad++; end
    check("stall_no_valid", bad, 32'd0);
    push(8'hCC); push(8'hDD);
    wait_valid("stall_valid_timeout", 50);
    check("stall_data", data,      32'hDDCCBBAA);
    check("stall_addr", 32'(addr), 32'd3);
    ready = 1'b1;
    step;
    check("last_done", 32'(done), 32'd1);
    check("last_busy", 32'(busy), 32'd0);
    ready = 1'b0;
    step;
    check("last_done_lo", 32'(done), 32'd0);

    // Full 4-row load with a stray start while busy.
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    h0 = got_n; d0 = done_cnt;
    start = 1'b1; step; start = 1'b0; ready = 1'b1;
    repeat (8) step;
    start = 1'b1; step; start = 1'b0;
    n = 0;
    while (!done && n < 200) begin step; n++; end
    check("full_done_seen", 32'(done), 32'd1);
    check("full_busy_lo",   32'(busy), 32'd0);
    step;
    check("full_done_1cyc", 32'(done), 32'd0);
    check("full_rows", got_n - h0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 4; b++) e[8*b +: 8] = 8'h20 + 8'(4*i + b);
      check("full_addr", 32'(got_addr[h0+i]), i);
      check("full_data", got_data[h0+i], e);
    end
    repeat (10) step;
    check("full_idle_busy", 32'(busy),     32'd0);
    check("full_no_extra",  got_n - h0,    32'd4);
    check("full_one_done",  done_cnt - d0, 32'd1);
    ready = 1'b0;

    // Reset with two words captured and a read in flight.
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    start = 1'b1; step; start = 1'b0;
    repeat (3) step;
    rst = 1'b1;
    step;
    check("mrst_busy",  32'(busy),  32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_rd_en", 32'(rd_en), 32'd0);
    check("mrst_data",  data,       32'd0);
    check("mrst_addr",  32'(addr),  32'd0);
    rst = 1'b0;
    step;
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    start = 1'b1; step; start = 1'b0;
    wait_valid("mrst_valid_timeout", 50);
    check("mrst_new_data", data,      32'h14131211);
    check("mrst_new_addr", 32'(addr), 32'd0);
    rst = 1'b1; step; rst = 1'b0; step;

    // Random FIFO availability and ready over 16 loads of 4 rows.
    for (int i = 0; i < 256; i++) exp_b[i] = 8'($urandom_range(0, 255));
    h0 = got_n; d0 = done_cnt; loads = 0; pushed = 0;
    for (int c = 0; c < 20000 && !((got_n - h0) == 64 && (done_cnt - d0) == 16); c++) begin
      step;
      if (pushed < 256 && $urandom_range(0, 2) != 0) begin
        push(exp_b[pushed]);
        pushed++;
      end
      ready = 1'($urandom_range(0, 1));
      if (start) start = 1'b0;
      else if (loads < 16 && !busy && !done) begin
        start = 1'b1;
        loads++;
      end
    end
    start = 1'b0; ready = 1'b0;
    check("rand_rows",  got_n - h0,    32'd64);
    check("rand_dones", done_cnt - d0, 32'd16);
    bad = 0;
    for (int i = 0; i < 64 && h0 + i < got_n; i++) begin
      e = {exp_b[4*i+3], exp_b[4*i+2], exp_b[4*i+1], exp_b[4*i]};
      if (got_data[h0+i] !== e || got_addr[h0+i] !== 2'(i % 4)) begin
        bad++;
        $display("FAIL rand_row%0d: got %0h@%0d expected %0h@%0d",
                 i, got_data[h0+i], got_addr[h0+i], e, i % 4);
      end
    end
    check("rand_scoreboard", bad, 32'd0);
    check("rd_en_while_empty", viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spin_row_assembler.md
Name: spin_row_assembler

Overview:
- Read-side consumer of the byte FIFO in the Ising spin-load path.
- Drains WIDTH-bit words from the FIFO and packs BYTES_PER_ROW consecutive words into one ROW_BITS-wide spin row.
- Presents each row, with its row address, on a valid/ready port to the spin/coupling memory writer.
- Loads exactly NUM_ROWS rows per start command, then pulses done.

Parameters:
- WIDTH, 8: FIFO word width in bits.
- ROW_BITS, 32: output row width in bits. Must be an integer multiple of WIDTH. BYTES_PER_ROW = ROW_BITS/WIDTH, must be ≥1.
- NUM_ROWS, 32: rows loaded per start command. Must be ≥1.
- ADDR_WIDTH, $clog2(NUM_ROWS) (minimum 1): row address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a load. Sampled only in IDLE.
- busy  out  1  high in LOAD and OUT states.
- done  out  1  one-cycle pulse after the final row handshake.
- fifo_rd_en  out  1  FIFO read request.
- fifo_dout  in  WIDTH  FIFO registered read data. Valid the cycle after an accepted rd_en, then held.
- fifo_empty  in  1  FIFO empty flag (combinational in FIFO).
- row_valid  out  1  row_data and row_addr are valid.
- row_ready  in  1  downstream accepts the row.
- row_data  out  ROW_BITS  assembled row.
- row_addr  out  ADDR_WIDTH  row index, 0..NUM_ROWS-1.

Behaviour:
- Reset values: busy=0, done=0, fifo_rd_en=0, row_valid=0, row_data=0, row_addr=0. Internal: state=IDLE, issue/capture counters=0, pending=0.
- States:
  - IDLE: start=1 → LOAD; clear row_addr and counters.
  - LOAD: issue reads and capture bytes. When captured count reaches BYTES_PER_ROW → OUT.
  - OUT: row_valid=1. On row_valid&&row_ready: if row_addr==NUM_ROWS-1 → DONE; else row_addr+1, clear counters → LOAD.
  - DONE: done=1 for one cycle → IDLE.
- fifo_rd_en is combinational:
  - = (state==LOAD) && !fifo_empty && (issued < BYTES_PER_ROW).
  - Never asserted while empty, so every request is accepted.
  - Back-to-back reads allowed; one read per cycle.
- Capture:
  - pending is a register loaded with fifo_rd_en each cycle.
  - When pending=1, fifo_dout is written into row_data slice [captured*WIDTH +: WIDTH] and captured increments.
  - First byte lands in LSBs.
- Stall on empty: reads stop while fifo_empty=1. Partial row and counters are retained, and resume without loss or duplication.
- Latency, FIFO non-empty throughout:
  - start high in cycle 0 → fifo_rd_en high cycles 1..BYTES_PER_ROW → row_valid high in cycle BYTES_PER_ROW+2.
  - Handshake in cycle k → next row_valid in cycle k+BYTES_PER_ROW+2.
- OUT hold: row_data and row_addr are stable while row_valid=1 and row_ready=0. fifo_rd_en=0 in OUT, so no prefetch.
- row_ready is ignored when row_valid=0.
- done pulses in the cycle after the final handshake. busy is low in that cycle.
- start while busy or in DONE is ignored.
- start held high across DONE → IDLE re-arms in the next IDLE cycle and begins a new load at row_addr=0.
- Reset mid-operation:
  - Returns to IDLE next cycle with all outputs at reset values.
  - Any in-flight FIFO read data is discarded (pending cleared).
  - The FIFO is reset by the same rst.
- NUM_ROWS=1: first handshake → DONE.

Test Plan:
1. Reset, then preload FIFO with 0x01..0x08, start pulse, row_ready=1:
   - row0: row_data=0x04030201, row_addr=0, row_valid in cycle 6.
   - row1: row_data=0x08070605, row_addr=1.
2. Backpressure:
   - row_ready=0 for 5 cycles in OUT → row_data/row_addr constant, fifo_rd_en=0.
   - Then ready=1 → exactly one handshake.
3. Empty stall:
   - Push 0xAA,0xBB, start; after 10 idle cycles push 0xCC,0xDD.
   - Expect row_data=0xDDCCBBAA.
   - fifo_rd_en never high while fifo_empty=1; no row_valid during the stall.
4. Full load with NUM_ROWS=4, 16 bytes pushed:
   - Addresses 0,1,2,3 in order.
   - done high for exactly one cycle after the 4th handshake; busy then 0.
   - start during busy has no effect.
5. Reset mid-row:
   - Assert rst after 2 bytes captured → outputs reset next cycle.
   - New start with fresh bytes 0x11..0x14 → row_data=0x14131211, row_addr=0.
6. Random valid/ready and FIFO-empty toggling over 64 rows:
   - Scoreboard byte order matches pushes.
   - No drop or duplicate.
   - Never (fifo_rd_en && fifo_empty).
